// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell and result codes, referee states and
// the board indexing helper used by the referee and the display logic.
package ttt_pkg;

    localparam logic [1:0] CELL_P1    = 2'd0;
    localparam logic [1:0] CELL_P2    = 2'd1;
    localparam logic [1:0] CELL_EMPTY = 2'd2;

    localparam logic [1:0] WIN_P1      = 2'd0;
    localparam logic [1:0] WIN_P2      = 2'd1;
    localparam logic [1:0] DRAW        = 2'd2;
    localparam logic [1:0] IN_PROGRESS = 2'd3;

    localparam int         NUM_CELLS   = 9;
    localparam logic [3:0] MAX_MOVES   = 4'd9;
    localparam logic [17:0] BOARD_EMPTY = {9{CELL_EMPTY}};

    typedef enum logic [1:0] {
        TURN  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Row-major cell number; callers must have range-checked row and col.
    function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
        return ({2'b00, row} * 4'd3) + {2'b00, col};
    endfunction

endpackage

// File: rtl/game_referee_if.sv
// Player move handshake: the active player drives a (row, col) offer and the
// referee answers with ready and a one-cycle rejection pulse.
interface game_referee_if;

    logic       move_valid;
    logic [1:0] move_row;
    logic [1:0] move_col;
    logic       move_ready;
    logic       move_err;

    modport master (
        output move_valid,
        output move_row,
        output move_col,
        input  move_ready,
        input  move_err
    );

    modport slave (
        input  move_valid,
        input  move_row,
        input  move_col,
        output move_ready,
        output move_err
    );

endinterface

// File: rtl/line_checker.sv
// Combinational three-in-a-row detector for one player code on a flattened
// 3x3 board; shared by the referee and the win display.
module line_checker
    import ttt_pkg::*;
(
    input  logic [17:0] i_board,
    input  logic [1:0]  i_player,
    output logic        o_win
);

    logic [8:0] w_own;
    logic [2:0] w_row_win;
    logic [2:0] w_col_win;
    logic [1:0] w_diag_win;

    // Ownership mask: bit n set when cell n holds the queried player's mark
    always_comb begin
        w_own = 9'd0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            w_own[i] = (i_board[2*i +: 2] == i_player);
        end
    end

    // Evaluate the three rows, three columns and both diagonals
    always_comb begin
        w_row_win  = 3'd0;
        w_col_win  = 3'd0;
        for (int r = 0; r < 3; r++) begin
            w_row_win[r] = w_own[3*r] & w_own[3*r + 1] & w_own[3*r + 2];
            w_col_win[r] = w_own[r]   & w_own[r + 3]   & w_own[r + 6];
        end
        w_diag_win[0] = w_own[0] & w_own[4] & w_own[8];
        w_diag_win[1] = w_own[2] & w_own[4] & w_own[6];
    end

    assign o_win = (|w_row_win) | (|w_col_win) | (|w_diag_win);

endmodule

// File: rtl/game_referee.sv
// Tic-tac-toe referee: owns the board, validates moves from the active player,
// alternates turns and registers the game result.
module game_referee
    import ttt_pkg::*;
#(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          new_game,
    game_referee_if.slave mv,
    output logic          cur_player,
    output logic [17:0]   board_flat,
    output logic [1:0]    who_won,
    output logic          game_over
);

    state_t      r_state;
    logic [17:0] r_board;
    logic [3:0]  r_count;
    logic        r_player;
    logic [1:0]  r_who;
    logic        r_err;
    logic        r_ready;

    state_t      w_state_nxt;
    logic [17:0] w_board_nxt;
    logic [3:0]  w_count_nxt;
    logic        w_player_nxt;
    logic [1:0]  w_who_nxt;
    logic        w_err_nxt;
    logic        w_ready_nxt;

    logic        w_in_range;
    logic [3:0]  w_idx;
    logic [1:0]  w_cell;
    logic        w_legal;
    logic [1:0]  w_mover;
    logic        w_win;

    assign w_mover = r_player ? CELL_P2 : CELL_P1;

    // The board checked during CHECK already carries the mover's new mark
    line_checker u_line_checker (
        .i_board  (r_board),
        .i_player (w_mover),
        .o_win    (w_win)
    );

    // Decode the offered coordinates; the index is only formed once in range
    always_comb begin
        w_in_range = (mv.move_row != 2'd3) && (mv.move_col != 2'd3);
        if (w_in_range) begin
            w_idx = cell_index(mv.move_row, mv.move_col);
        end else begin
            w_idx = 4'd0;
        end
        w_cell  = r_board[{w_idx, 1'b0} +: 2];
        w_legal = w_in_range && (w_cell == CELL_EMPTY);
    end

    // Next-state and next-output decode; new_game overrides everything
    always_comb begin
        w_state_nxt  = r_state;
        w_board_nxt  = r_board;
        w_count_nxt  = r_count;
        w_player_nxt = r_player;
        w_who_nxt    = r_who;
        w_err_nxt    = 1'b0;

        if (new_game) begin
            w_state_nxt  = TURN;
            w_board_nxt  = BOARD_EMPTY;
            w_count_nxt  = 4'd0;
            w_player_nxt = FIRST_PLAYER;
            w_who_nxt    = IN_PROGRESS;
        end else begin
            case (r_state)
                TURN: begin
                    if (mv.move_valid && r_ready) begin
                        if (w_legal) begin
                            w_board_nxt[{w_idx, 1'b0} +: 2] = w_mover;
                            w_count_nxt = (r_count < MAX_MOVES) ? (r_count + 4'd1) : r_count;
                            w_state_nxt = CHECK;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else begin
                        w_err_nxt = 1'b0;
                    end
                end
                CHECK: begin
                    // A completed line takes priority over a full board
                    if (w_win) begin
                        w_who_nxt   = r_player ? WIN_P2 : WIN_P1;
                        w_state_nxt = DONE;
                    end else if (r_count == MAX_MOVES) begin
                        w_who_nxt   = DRAW;
                        w_state_nxt = DONE;
                    end else begin
                        w_player_nxt = ~r_player;
                        w_state_nxt  = TURN;
                    end
                end
                DONE: begin
                    w_state_nxt = DONE;
                end
                default: begin
                    w_state_nxt = TURN;
                end
            endcase
        end

        w_ready_nxt = (w_state_nxt == TURN);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= TURN;
            r_board  <= BOARD_EMPTY;
            r_count  <= 4'd0;
            r_player <= FIRST_PLAYER;
            r_who    <= IN_PROGRESS;
            r_err    <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_board  <= w_board_nxt;
            r_count  <= w_count_nxt;
            r_player <= w_player_nxt;
            r_who    <= w_who_nxt;
            r_err    <= w_err_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign mv.move_ready = r_ready;
    assign mv.move_err   = r_err;
    assign cur_player    = r_player;
    assign board_flat    = r_board;
    assign who_won       = r_who;
    assign game_over     = (r_who != IN_PROGRESS);

endmodule

// File: tb/tb_game_referee.sv
// Self-checking bench for game_referee: a behavioural tic-tac-toe model feeds
// a queue of expected outcomes that is drained as the referee responds.
module tb_game_referee;
    import ttt_pkg::*;

    localparam logic FP = 1'b0;

    typedef struct packed {
        logic        err;
        logic [17:0] board;
        logic [1:0]  who;
        logic        player;
        logic        ready;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        new_game;
    logic        cur_player;
    logic [17:0] board_flat;
    logic [1:0]  who_won;
    logic        game_over;

    game_referee_if mv_if ();

    game_referee #(.FIRST_PLAYER(FP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_game   (new_game),
        .mv         (mv_if),
        .cur_player (cur_player),
        .board_flat (board_flat),
        .who_won    (who_won),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0] mboard [9];
    logic       mplayer;
    logic [3:0] mcount;
    logic [1:0] mwho;
    exp_t       sb [$];

    function automatic logic [17:0] model_flat();
        logic [17:0] b;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = mboard[i];
        return b;
    endfunction

    function automatic logic model_win(input logic [1:0] p);
        logic [8:0] o;
        for (int i = 0; i < 9; i++) o[i] = (mboard[i] == p);
        return (o[0] & o[1] & o[2]) | (o[3] & o[4] & o[5]) | (o[6] & o[7] & o[8]) |
               (o[0] & o[3] & o[6]) | (o[1] & o[4] & o[7]) | (o[2] & o[5] & o[8]) |
               (o[0] & o[4] & o[8]) | (o[2] & o[4] & o[6]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) mboard[i] = CELL_EMPTY;
        mplayer = FP;
        mcount  = 4'd0;
        mwho    = IN_PROGRESS;
    endtask

    task automatic model_move(input logic [1:0] row, input logic [1:0] col);
        logic legal;
        int   idx;
        exp_t e;
        legal = (row < 2'd3) && (col < 2'd3);
        idx   = legal ? (int'(row) * 3 + int'(col)) : 0;
        if (legal && (mboard[idx] != CELL_EMPTY)) legal = 1'b0;
        if (legal) begin
            mboard[idx] = mplayer ? CELL_P2 : CELL_P1;
            mcount      = mcount + 4'd1;
            if (model_win(mboard[idx])) mwho = mplayer ? WIN_P2 : WIN_P1;
            else if (mcount == 4'd9)    mwho = DRAW;
            else                        mplayer = ~mplayer;
        end
        e.err    = ~legal;
        e.board  = model_flat();
        e.who    = mwho;
        e.player = mplayer;
        e.ready  = (mwho == IN_PROGRESS);
        sb.push_back(e);
    endtask

    // Entered and left on a falling edge; offers one move and checks the response
    task automatic offer(input logic [1:0] row, input logic [1:0] col);
        exp_t e;
        int   waited = 0;
        while ((mv_if.move_ready !== 1'b1) && (waited < 10)) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (mv_if.move_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout row=%0d col=%0d ready=%b required 1", row, col, mv_if.move_ready);
            return;
        end
        model_move(row, col);
        mv_if.move_valid = 1'b1;
        mv_if.move_row   = row;
        mv_if.move_col   = col;
        @(negedge clk);
        mv_if.move_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (mv_if.move_err !== e.err) begin
            errors++;
            $display("FAIL move_err (%0d,%0d) got %b required %b", row, col, mv_if.move_err, e.err);
        end
        checks++;
        if (board_flat !== e.board) begin
            errors++;
            $display("FAIL board_after_edge (%0d,%0d) got %h required %h", row, col, board_flat, e.board);
        end
        checks++;
        if (mv_if.move_ready !== e.err) begin
            errors++;
            $display("FAIL ready_in_check (%0d,%0d) got %b required %b", row, col, mv_if.move_ready, e.err);
        end
        checks++;
        if (!e.err && (who_won !== IN_PROGRESS)) begin
            errors++;
            $display("FAIL who_won_early (%0d,%0d) got %0d required 3", row, col, who_won);
        end
        @(negedge clk);
        checks++;
        if (mv_if.move_err !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle (%0d,%0d) got %b required 0", row, col, mv_if.move_err);
        end
        checks++;
        if (who_won !== e.who) begin
            errors++;
            $display("FAIL who_won (%0d,%0d) got %0d required %0d", row, col, who_won, e.who);
        end
        checks++;
        if (cur_player !== e.player) begin
            errors++;
            $display("FAIL cur_player (%0d,%0d) got %b required %b", row, col, cur_player, e.player);
        end
        checks++;
        if (mv_if.move_ready !== e.ready) begin
            errors++;
            $display("FAIL ready_after (%0d,%0d) got %b required %b", row, col, mv_if.move_ready, e.ready);
        end
        checks++;
        if (game_over !== (e.who != IN_PROGRESS)) begin
            errors++;
            $display("FAIL game_over (%0d,%0d) got %b required %b", row, col, game_over, (e.who != IN_PROGRESS));
        end
    endtask

    task automatic start_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_reset();
        checks++;
        if ((board_flat !== model_flat()) || (who_won !== IN_PROGRESS) || (mv_if.move_ready !== 1'b1)) begin
            errors++;
            $display("FAIL start_game board=%h who=%0d ready=%b required %h 3 1",
                     board_flat, who_won, mv_if.move_ready, model_flat());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (board_flat !== model_flat()) begin
            errors++;
            $display("FAIL reset_board got %h required %h", board_flat, model_flat());
        end
        checks++;
        if ((who_won !== IN_PROGRESS) || (game_over !== 1'b0)) begin
            errors++;
            $display("FAIL reset_result who=%0d over=%b required 3 0", who_won, game_over);
        end
        checks++;
        if ((mv_if.move_ready !== 1'b0) || (mv_if.move_err !== 1'b0) || (cur_player !== FP)) begin
            errors++;
            $display("FAIL reset_ctrl ready=%b err=%b player=%b required 0 0 %b",
                     mv_if.move_ready, mv_if.move_err, cur_player, FP);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mv_if.move_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b required 1", mv_if.move_ready);
        end
    endtask

    task automatic test_win_column();
        offer(2'd0, 2'd0);
        offer(2'd0, 2'd1);
        offer(2'd1, 2'd0);
        offer(2'd0, 2'd2);
        offer(2'd2, 2'd0);
        checks++;
        if ((board_flat[1:0] !== CELL_P1) || (board_flat[7:6] !== CELL_P1) || (board_flat[13:12] !== CELL_P1) ||
            (board_flat[3:2] !== CELL_P2) || (board_flat[5:4] !== CELL_P2)) begin
            errors++;
            $display("FAIL win_cells got %h required cells 0,3,6=0 and 1,2=1", board_flat);
        end
        checks++;
        if ((who_won !== WIN_P1) || (game_over !== 1'b1)) begin
            errors++;
            $display("FAIL win_result who=%0d over=%b required 0 1", who_won, game_over);
        end
    endtask

    task automatic test_done_hold();
        repeat (3) @(negedge clk);
        mv_if.move_valid = 1'b1;
        mv_if.move_row   = 2'd1;
        mv_if.move_col   = 2'd1;
        @(negedge clk);
        mv_if.move_valid = 1'b0;
        checks++;
        if ((mv_if.move_err !== 1'b0) || (mv_if.move_ready !== 1'b0)) begin
            errors++;
            $display("FAIL done_ignore err=%b ready=%b required 0 0", mv_if.move_err, mv_if.move_ready);
        end
        checks++;
        if ((board_flat !== model_flat()) || (who_won !== WIN_P1) || (cur_player !== 1'b0)) begin
            errors++;
            $display("FAIL done_hold board=%h who=%0d player=%b required %h 0 0",
                     board_flat, who_won, cur_player, model_flat());
        end
    endtask

    task automatic test_new_game_collision();
        new_game         = 1'b1;
        mv_if.move_valid = 1'b1;
        mv_if.move_row   = 2'd0;
        mv_if.move_col   = 2'd0;
        @(negedge clk);
        new_game         = 1'b0;
        mv_if.move_valid = 1'b0;
        model_reset();
        checks++;
        if ((board_flat !== model_flat()) || (board_flat[1:0] !== CELL_EMPTY)) begin
            errors++;
            $display("FAIL collision_board got %h required %h", board_flat, model_flat());
        end
        checks++;
        if ((mv_if.move_err !== 1'b0) || (cur_player !== FP) || (who_won !== IN_PROGRESS) || (game_over !== 1'b0)) begin
            errors++;
            $display("FAIL collision_ctrl err=%b player=%b who=%0d over=%b required 0 %b 3 0",
                     mv_if.move_err, cur_player, who_won, game_over, FP);
        end
        checks++;
        if (mv_if.move_ready !== 1'b1) begin
            errors++;
            $display("FAIL collision_ready got %b required 1", mv_if.move_ready);
        end
    endtask

    task automatic test_occupied();
        offer(2'd1, 2'd1);
        offer(2'd1, 2'd1);
        checks++;
        if ((board_flat[9:8] !== CELL_P1) || (cur_player !== 1'b1)) begin
            errors++;
            $display("FAIL occupied_hold cell4=%0d player=%b required 0 1", board_flat[9:8], cur_player);
        end
        offer(2'd2, 2'd2);
        checks++;
        if (cur_player !== 1'b0) begin
            errors++;
            $display("FAIL occupied_toggle player=%b required 0", cur_player);
        end
    endtask

    task automatic test_out_of_range();
        start_game();
        offer(2'd3, 2'd0);
        offer(2'd0, 2'd3);
        checks++;
        if ((board_flat !== BOARD_EMPTY) || (cur_player !== FP)) begin
            errors++;
            $display("FAIL range_hold board=%h player=%b required %h %b", board_flat, cur_player, BOARD_EMPTY, FP);
        end
    endtask

    // Continues the game left by test_out_of_range: a draw exactly on move 9
    task automatic test_draw();
        offer(2'd0, 2'd0); offer(2'd0, 2'd1); offer(2'd0, 2'd2);
        offer(2'd1, 2'd1); offer(2'd1, 2'd0); offer(2'd1, 2'd2);
        offer(2'd2, 2'd1); offer(2'd2, 2'd0); offer(2'd2, 2'd2);
        checks++;
        if ((who_won !== DRAW) || (game_over !== 1'b1)) begin
            errors++;
            $display("FAIL draw_result who=%0d over=%b required 2 1", who_won, game_over);
        end
    endtask

    task automatic test_win_on_last_move();
        start_game();
        offer(2'd0, 2'd0); offer(2'd0, 2'd1); offer(2'd0, 2'd2);
        offer(2'd1, 2'd0); offer(2'd2, 2'd1); offer(2'd1, 2'd1);
        offer(2'd1, 2'd2); offer(2'd2, 2'd0); offer(2'd2, 2'd2);
        checks++;
        if (who_won !== WIN_P1) begin
            errors++;
            $display("FAIL ninth_move_win who=%0d required 0", who_won);
        end
    endtask

    task automatic test_async_reset();
        start_game();
        offer(2'd0, 2'd0);
        offer(2'd1, 2'd1);
        offer(2'd2, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ((board_flat !== model_flat()) || (who_won !== IN_PROGRESS) || (mv_if.move_ready !== 1'b0)) begin
            errors++;
            $display("FAIL async_reset board=%h who=%0d ready=%b required %h 3 0",
                     board_flat, who_won, mv_if.move_ready, model_flat());
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (mv_if.move_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge got %b required 0", mv_if.move_ready);
        end
        @(negedge clk);
        checks++;
        if ((mv_if.move_ready !== 1'b1) || (board_flat !== model_flat()) || (cur_player !== FP)) begin
            errors++;
            $display("FAIL ready_after_release ready=%b board=%h player=%b required 1 %h %b",
                     mv_if.move_ready, board_flat, cur_player, model_flat(), FP);
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        new_game         = 1'b0;
        mv_if.move_valid = 1'b0;
        mv_if.move_row   = 2'd0;
        mv_if.move_col   = 2'd0;
        model_reset();

        test_reset();
        test_win_column();
        test_done_hold();
        test_new_game_collision();
        test_occupied();
        test_out_of_range();
        test_draw();
        test_win_on_last_move();
        test_async_reset();

        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t required completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/game_referee.md
Name: game_referee

Overview:
- Board-owning referee for the tic-tac-toe design; the responder side of the player move interface.
- Accepts (row, col) moves from the active player over a valid/ready handshake and rejects illegal moves.
- Writes the owner code into its internal 3x3 board, alternates turns, and registers the game result.
- Its flattened board output feeds the player and win-display logic.

Parameters:
- FIRST_PLAYER, 0, player code (0 or 1) whose turn starts every game.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- new_game  input  1  synchronous one-cycle request: clear board, restart game.
- move_valid  input  1  active player presents a move.
- move_row  input  2  row index, legal 0..2.
- move_col  input  2  column index, legal 0..2.
- move_ready  output  1  referee can accept a move this cycle.
- move_err  output  1  one-cycle pulse: last offered move was rejected.
- cur_player  output  1  player code whose turn it is.
- board_flat  output  18  cell (r,c) at bits [2*(3r+c)+1 : 2*(3r+c)]; codes 0=P1, 1=P2, 2=empty.
- who_won  output  2  0=P1 won, 1=P2 won, 2=draw, 3=game in progress.
- game_over  output  1  high while who_won != 3.

Behaviour:
- Reset (async, rst_n low):
  - all cells = 2 (empty); who_won = 3; move_ready = 0; move_err = 0; cur_player = FIRST_PLAYER; move count = 0; state = TURN.
  - Reset asserted mid-game aborts everything immediately; no partial write survives.
- States and transitions:
  - TURN: move_ready = 1.
  - CHECK: move_ready = 0.
  - DONE: move_ready = 0; game_over = 1.
- Handshake:
  - A move is offered when move_valid = 1 in TURN and is evaluated on that edge.
  - move_row/move_col are sampled only on that edge.
  - move_valid outside TURN is ignored; no error is raised.
- Legal move (row <= 2, col <= 2, target cell == 2):
  - At edge T the cell is written with cur_player, the move count increments, and state -> CHECK.
  - board_flat shows the new mark after edge T.
- Illegal move (row == 3, col == 3, or cell not empty):
  - At edge T, move_err = 1 for exactly one cycle.
  - Board, move count, cur_player and state are unchanged; stay in TURN.
- CHECK (exactly one cycle), resolved at edge T+1:
  - Three in a row for the mover (any of 8 lines: 3 rows, 3 cols, 2 diagonals): who_won = mover; state -> DONE.
  - Otherwise, move count == 9: who_won = 2 (draw); state -> DONE.
  - Otherwise: cur_player toggles; state -> TURN.
  - Net effect: move_ready re-asserts 2 cycles after an accepted move.
  - A win on the 9th move reports the win, not a draw.
- DONE:
  - Holds the board, who_won and cur_player until new_game or reset.
- new_game:
  - Takes effect at its edge from any state.
  - Clears the board, who_won = 3, count = 0, cur_player = FIRST_PLAYER, state -> TURN, move_err = 0.
  - new_game and move_valid in the same cycle: new_game wins; the move is dropped with no error.
- Arithmetic: move count is 4 bits, saturates at 9. Cell index = 3*row + col, computed only after the range check.
- All outputs are registered except game_over, which is decoded from who_won.

Decomposition:
- Shared package ttt_pkg:
  - cell codes P1 = 2'd0, P2 = 2'd1, EMPTY = 2'd2.
  - result codes WIN_P1 = 0, WIN_P2 = 1, DRAW = 2, IN_PROGRESS = 3.
  - state enum {TURN, CHECK, DONE}.
  - board index helper.
- One natural sub-module: line_checker. It is combinational: board plus player code in, "has three in a row" out. Reusable by the whoWon display logic.

Test Plan:
- Reset, then P1 (0,0), P2 (0,1), P1 (1,0), P2 (0,2), P1 (2,0):
  - expect who_won = 0, game_over = 1 two cycles after the last accept.
  - board_flat cells 0, 3, 6 = 0; cells 1, 2 = 1.
  - move_ready = 0 afterwards.
- After P1 (1,1), P2 offers (1,1):
  - expect a move_err single-cycle pulse; cell 4 stays 0; cur_player stays 1.
  - P2 then offers (2,2): accepted; cur_player toggles back to 0.
- Offer row = 3, col = 0 at game start:
  - expect move_err pulse; board all 2; move count 0; cur_player = FIRST_PLAYER.
- Full draw sequence P1 (0,0), P2 (0,1), P1 (0,2), P2 (1,1), P1 (1,0), P2 (1,2), P1 (2,1), P2 (2,0), P1 (2,2):
  - expect who_won = 2 only after the 9th move; who_won = 3 before it.
- Mid-game after 3 moves:
  - assert rst_n = 0 asynchronously between edges: board all 2, who_won = 3, move_ready = 0 immediately.
  - Release reset: move_ready = 1 on the next edge.
- In DONE:
  - assert new_game together with move_valid (0,0): board cleared, (0,0) stays 2, no move_err, cur_player = FIRST_PLAYER, who_won = 3.
